// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses N+1 cycles after start (1 for divide-by-zero).
// No backpressure: start is accepted only in IDLE, ignored otherwise, and results hold until the next completion.
module seq_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state;
    logic [N:0]    partial_rem;
    logic [N-1:0]  dvd_shift;
    logic [N-1:0]  dvs;
    logic [N-1:0]  quo_shift;
    logic [CW-1:0] count;

    logic [N:0]    shifted;
    logic [N-1:0]  dvd_next;
    logic [N+1:0]  diff;
    logic          borrow;
    logic [N:0]    rem_next;
    logic [N-1:0]  quo_next;

    // Dividend MSB moves into the partial remainder LSB; the top bit of the
    // partial remainder is always zero because it stays below the divisor.
    always_comb begin
        {shifted, dvd_next} = {partial_rem, dvd_shift} << 1;
        diff     = {1'b0, shifted} - {2'b00, dvs};
        borrow   = diff[N+1];
        rem_next = borrow ? shifted : diff[N:0];
        quo_next = (quo_shift << 1) | {{(N-1){1'b0}}, ~borrow};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            partial_rem <= '0;
            dvd_shift   <= '0;
            dvs         <= '0;
            quo_shift   <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            dvd_shift   <= dividend;
                            dvs         <= divisor;
                            partial_rem <= '0;
                            quo_shift   <= '0;
                            count       <= '0;
                            busy        <= 1'b1;
                            state       <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    partial_rem <= rem_next;
                    dvd_shift   <= dvd_next;
                    quo_shift   <= quo_next;
                    count       <= count + 1'b1;
                    if (count == LAST) begin
                        quotient    <= quo_next;
                        remainder   <= rem_next[N-1:0];
                        div_by_zero <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative restoring divider producing an unsigned quotient and remainder over N clock cycles. It is the inverse companion to the adder/subtractor and multiply paths in the arithmetic unit. It uses the same subtract-with-borrow rule as the ripple subtractor, applied one bit per cycle through a shift-subtract-restore loop. A start/busy/done handshake lets a controlling FSM launch one division at a time and collect registered results.

## Interface
- N, default 8: operand, quotient and remainder width in bits (N ≥ 2).
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  N  unsigned dividend; sampled on the accepted start edge.
- divisor  input  N  unsigned divisor; sampled on the accepted start edge.
- quotient  output  N  registered quotient; holds until the next completion.
- remainder  output  N  registered remainder; holds until the next completion.
- busy  output  1  high while a division is in progress (RUN state).
- done  output  1  one-cycle completion pulse (DONE state).
- div_by_zero  output  1  registered flag for the last completed division; holds with the results.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- Reset values: quotient=0, remainder=0, busy=0, done=0, div_by_zero=0. Internal accumulator and counter are cleared.
- IDLE:
  - start=0: stay in IDLE.
  - start=1 and divisor≠0: latch both operands, clear the (N+1)-bit partial remainder, set the iteration counter to 0, go to RUN.
  - start=1 and divisor=0: go directly to DONE and load quotient={N{1}}, remainder=dividend, div_by_zero=1.
- RUN, one iteration per cycle:
  - Shift {partial_rem, dividend_shift} left by 1. The MSB of the dividend enters the LSB of partial_rem.
  - Trial-subtract: t = partial_rem − {0,divisor}, computed N+1 bits wide.
  - No borrow: partial_rem=t and the new quotient LSB is 1.
  - Borrow: partial_rem is kept (restore) and the new quotient LSB is 0.
  - After the Nth iteration, load the quotient/remainder outputs, clear div_by_zero, and go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally return to IDLE.
- start in RUN or DONE is ignored, with no queuing. Operand changes after acceptance have no effect.
- quotient, remainder and div_by_zero change only on entry to DONE; at all other times they hold their values.
- Arithmetic invariant for divisor≠0: dividend = quotient·divisor + remainder, with remainder < divisor.
- Reset during RUN or DONE aborts the division:
  - no done pulse is produced;
  - outputs return to their reset values on that edge.
- reset and start high on the same edge: reset wins.

## Timing
- Cycle 0: start=1 while in IDLE; sampled at the end of cycle 0.
- Normal path:
  - Cycles 1..N: busy=1, done=0.
  - Cycle N+1: done=1, busy=0, results valid.
  - Cycle N+2: back in IDLE. The earliest next accepted start is sampled at the end of cycle N+2.
  - Throughput is one division per N+2 cycles.
- Divide-by-zero path:
  - Cycle 1: done=1, div_by_zero=1, busy never asserts.
  - Cycle 2: IDLE.
- busy and done are never high in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- N=8, dividend=100, divisor=7, start in cycle 0 -> busy high in cycles 1..8, done in cycle 9, quotient=14, remainder=2, div_by_zero=0.
- dividend=255, divisor=1 -> quotient=255, remainder=0. dividend=3, divisor=200 -> quotient=0, remainder=3. dividend=255, divisor=255 -> quotient=1, remainder=0.
- dividend=5, divisor=0 -> done in cycle 1, quotient=255, remainder=5, div_by_zero=1, busy never high. A following 9/3 division then completes with quotient=3, remainder=0, div_by_zero=0.
- Start 100/7. Hold start=1 and change operands to 50/5 during cycles 1..9 -> the result is still 14 r 2, and exactly one done pulse occurs. A start sampled in cycle 10 is accepted.
- Start 100/7, then assert reset in cycle 4 -> no done pulse, all outputs are 0 from cycle 5, and the state is IDLE. A new 20/6 start then yields 3 r 2 with normal latency.
- Randomized sweep of 1000 operand pairs, including divisor=0 -> each result checked against dividend/divisor and dividend%divisor (all-ones/dividend for zero), with latency exactly N+1 (or 1 for divide-by-zero).
